// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush, and invalid-payload idling.
// Define PIPE_STAGE_SKID_EN for the two-entry skid buffer with a registered in_ready.
module pipe_stage_reg #(
    parameter int              INSTR_W  = 32,
    parameter int              PC_W     = 32,
    parameter int              SIDE_W   = 8,
    parameter logic [PC_W-1:0] PC_RESET = 32'h0000_3000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [SIDE_W-1:0]  in_side,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic [SIDE_W-1:0]  out_side,
    output logic [1:0]         occupancy
);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
        logic [SIDE_W-1:0]  side;
    } entry_t;

    // State encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam entry_t NOP_ENTRY = '{instr: '0, pc: PC_RESET, side: '0};

    state_t state, state_next;
    entry_t main_q, main_d;
    entry_t in_entry;
    logic   accept, transfer;

    assign in_entry  = '{instr: in_instr, pc: in_pc, side: in_side};
    assign out_valid = (state != ST_EMPTY);
    assign accept    = in_valid && in_ready;
    assign transfer  = out_valid && out_ready;
    assign occupancy = state;
    assign out_instr = main_q.instr;
    assign out_pc    = main_q.pc;
    assign out_side  = main_q.side;

`ifdef PIPE_STAGE_SKID_EN
    entry_t skid_q, skid_d;
    logic   in_ready_q;

    // NOTE: in_ready is a flop, so out_ready never reaches upstream combinationally.
    assign in_ready = in_ready_q;
`else
    assign in_ready = !out_valid || out_ready;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        state_next = state;
        main_d     = main_q;
`ifdef PIPE_STAGE_SKID_EN
        skid_d     = skid_q;
`endif
        if (flush) begin
            state_next = ST_EMPTY;
            main_d     = NOP_ENTRY;
`ifdef PIPE_STAGE_SKID_EN
            skid_d     = NOP_ENTRY;
`endif
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state_next = ST_ONE;
                        main_d     = in_entry;
                    end
                end
                ST_ONE: begin
                    if (accept && transfer) begin
                        main_d = in_entry;
`ifdef PIPE_STAGE_SKID_EN
                    end else if (accept) begin
                        state_next = ST_FULL;
                        skid_d     = in_entry;
`endif
                    end else if (transfer) begin
                        state_next = ST_EMPTY;
                        main_d     = NOP_ENTRY;
                    end
                end
`ifdef PIPE_STAGE_SKID_EN
                ST_FULL: begin
                    // Skid is always the younger entry, so it moves up behind the departing head.
                    if (transfer) begin
                        state_next = ST_ONE;
                        main_d     = skid_q;
                        skid_d     = NOP_ENTRY;
                    end
                end
`endif
                default: begin
                    state_next = ST_EMPTY;
                    main_d     = NOP_ENTRY;
                end
            endcase
        end
    end

    // NOTE: payloads are reset too, so an idle stage always presents a defined NOP and PC.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_EMPTY;
            main_q     <= NOP_ENTRY;
`ifdef PIPE_STAGE_SKID_EN
            skid_q     <= NOP_ENTRY;
            in_ready_q <= 1'b1;
`endif
        end else begin
            state      <= state_next;
            main_q     <= main_d;
`ifdef PIPE_STAGE_SKID_EN
            skid_q     <= skid_d;
            in_ready_q <= (state_next != ST_FULL);
`endif
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: a default-width instance and a narrow instance
// (16/24/1, PC_RESET 24'hBFC000) share stimulus and are checked every cycle.
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [7:0]  side;
    } entry_t;

    localparam logic [31:0] PC_RST   = 32'h0000_3000;
    localparam logic [23:0] PC_RST_W = 24'hBFC000;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] in_instr, in_pc;
    logic [7:0]  in_side;
    logic        in_ready, out_valid;
    logic [31:0] out_instr, out_pc;
    logic [7:0]  out_side;
    logic [1:0]  occupancy;

    logic [15:0] w_in_instr, w_out_instr;
    logic [23:0] w_in_pc, w_out_pc;
    logic        w_in_side, w_out_side;
    logic        w_in_ready, w_out_valid;
    logic [1:0]  w_occupancy;

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .in_side(in_side),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .out_side(out_side),
        .occupancy(occupancy)
    );

    pipe_stage_reg #(.INSTR_W(16), .PC_W(24), .SIDE_W(1), .PC_RESET(24'hBFC000)) dut_w (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(w_in_ready),
        .in_instr(w_in_instr), .in_pc(w_in_pc), .in_side(w_in_side),
        .out_valid(w_out_valid), .out_ready(out_ready),
        .out_instr(w_out_instr), .out_pc(w_out_pc), .out_side(w_out_side),
        .occupancy(w_occupancy)
    );

    int     n_tests = 0;
    int     n_fail  = 0;
    int     cyc     = 0;
    entry_t stim_q[$];
    entry_t model_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL c%0d %s: got %h expected %h", cyc, tag, got, exp);
        end
    endtask

    task automatic push_stim(input logic [31:0] pc, input logic [31:0] instr, input logic [7:0] side);
        entry_t e;
        e.instr = instr;
        e.pc    = pc;
        e.side  = side;
        stim_q.push_back(e);
    endtask

    // One cycle: drive at negedge, check against the model, then advance the model.
    task automatic step(input bit offer, input bit ordy, input bit fl, input bit rst);
        entry_t cur;
        entry_t head;
        bit     exp_rdy, acc, xfer;
        @(negedge clk);
        cyc++;
        in_valid   = offer && (stim_q.size() > 0);
        cur        = in_valid ? stim_q[0] : '0;
        in_instr   = cur.instr;
        in_pc      = cur.pc;
        in_side    = cur.side;
        w_in_instr = cur.instr[15:0];
        w_in_pc    = cur.pc[23:0];
        w_in_side  = cur.side[0];
        out_ready  = ordy;
        flush      = fl;
        reset      = rst;
        #1;
        exp_rdy = SKID ? (model_q.size() < 2) : ((model_q.size() == 0) || ordy);
        if (model_q.size() > 0) head = model_q[0];
        else begin
            head.instr = '0;
            head.pc    = PC_RST;
            head.side  = '0;
        end
        check("out_valid", {31'd0, out_valid}, {31'd0, model_q.size() > 0});
        check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        check("occupancy", {30'd0, occupancy}, model_q.size());
        check("out_instr", out_instr, head.instr);
        check("out_pc", out_pc, head.pc);
        check("out_side", {24'd0, out_side}, {24'd0, head.side});
        check("w_out_valid", {31'd0, w_out_valid}, {31'd0, model_q.size() > 0});
        check("w_in_ready", {31'd0, w_in_ready}, {31'd0, exp_rdy});
        check("w_occupancy", {30'd0, w_occupancy}, model_q.size());
        check("w_out_instr", {16'd0, w_out_instr}, {16'd0, head.instr[15:0]});
        check("w_out_pc", {8'd0, w_out_pc}, {8'd0, (model_q.size() > 0) ? head.pc[23:0] : PC_RST_W});
        check("w_out_side", {31'd0, w_out_side}, {31'd0, head.side[0]});
        acc  = in_valid && exp_rdy;
        xfer = (model_q.size() > 0) && ordy;
        if (acc) void'(stim_q.pop_front());
        if (rst || fl) model_q.delete();
        else begin
            if (xfer) void'(model_q.pop_front());
            if (acc) model_q.push_back(cur);
        end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0; in_side = '0;
        w_in_instr = '0; w_in_pc = '0; w_in_side = 1'b0;
        repeat (2) @(posedge clk);

        // Reset values while idle
        repeat (2) step(0, 0, 0, 0);

        // Streaming with no bubbles
        for (int i = 0; i < 3; i++) push_stim(32'h3000 + 4 * i, 32'h2408_0001 + i, 8'(i + 1));
        repeat (3) step(1, 1, 0, 0);
        repeat (2) step(0, 1, 0, 0);

        // Stall with 0x3004 at head, 0x3008 offered
        for (int i = 0; i < 3; i++) push_stim(32'h3000 + 4 * i, 32'h2408_0011 + i, 8'hA0 + 8'(i));
        repeat (2) step(1, 1, 0, 0);
        repeat (3) step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        repeat (3) step(0, 1, 0, 0);

        // Flush while full with 0x300C offered
        push_stim(32'h3010, 32'h1111_0001, 8'h01);
        push_stim(32'h3014, 32'h1111_0002, 8'h02);
        push_stim(32'h300C, 32'h1111_0003, 8'h03);
        repeat (2) step(1, 0, 0, 0);
        step(1, 0, 1, 0);
        stim_q.delete();
        repeat (2) step(0, 0, 0, 0);

        // Flush with a real accept and transfer in the same cycle, then accept right after
        push_stim(32'h3018, 32'h2222_0001, 8'h11);
        step(1, 1, 0, 0);
        push_stim(32'h300C, 32'h2222_0002, 8'h12);
        step(1, 1, 1, 0);
        push_stim(32'h301C, 32'h2222_0003, 8'h13);
        step(1, 1, 0, 0);
        repeat (2) step(0, 1, 0, 0);

        // Reset while full with flush also high
        push_stim(32'h3020, 32'h3333_0001, 8'h21);
        push_stim(32'h3024, 32'h3333_0002, 8'h22);
        repeat (2) step(1, 0, 0, 0);
        step(0, 0, 1, 1);
        stim_q.delete();
        repeat (2) step(0, 0, 0, 0);

        // Random traffic with occasional flush
        for (int i = 0; i < 400; i++) begin
            if (stim_q.size() < 3 && $urandom_range(0, 3) != 0)
                push_stim($urandom, $urandom, 8'($urandom));
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 29) == 0, 1'b0);
        end
        stim_q.delete();
        repeat (4) step(0, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
